// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory port-B arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_e;

  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

  // Width able to hold 0..burst; never narrower than one bit.
  function automatic int cnt_width(input int burst);
    if (burst < 1) begin
      return 1;
    end else begin
      return $clog2(burst + 1);
    end
  endfunction

endpackage

// File: rtl/mem_port_arbiter_rr_pick.sv
// Two-input round-robin picker: on a tie the pointer decides, otherwise the lone requester wins.
module rr_pick
  import mem_arb_pkg::*;
(
  input  logic req0_i,
  input  logic req1_i,
  input  logic ptr_i,
  output logic win_o
);

  // Winner select; with no request the result is unused by the caller.
  always_comb begin
    win_o = REQ0;
    if (req0_i && req1_i) begin
      win_o = ptr_i;
    end else if (req1_i) begin
      win_o = REQ1;
    end else begin
      win_o = REQ0;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares memory port B between two requesters with round-robin and a bounded burst lock,
// and routes the one-cycle read return back to the requester that issued it.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int DATA  = 18,
  parameter int ADDR  = 14,
  parameter int BURST = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            r0_req,
  input  logic            r0_we,
  input  logic [ADDR-1:0] r0_addr,
  input  logic [DATA-1:0] r0_wdata,
  output logic            r0_gnt,
  output logic            r0_rvalid,
  input  logic            r1_req,
  input  logic            r1_we,
  input  logic [ADDR-1:0] r1_addr,
  input  logic [DATA-1:0] r1_wdata,
  output logic            r1_gnt,
  output logic            r1_rvalid,
  output logic [DATA-1:0] rdata,
  output logic            mem_wr,
  output logic [ADDR-1:0] mem_addr,
  output logic [DATA-1:0] mem_din,
  input  logic [DATA-1:0] mem_dout
);

  localparam int            CW        = cnt_width(BURST);
  localparam logic [CW-1:0] LAST_BEAT = CW'(BURST - 1);

  arb_state_e    state_q,    state_d;
  logic          rr_ptr_q,   rr_ptr_d;
  logic [CW-1:0] beat_cnt_q, beat_cnt_d;
  logic          rd_pend0_q, rd_pend0_d;
  logic          rd_pend1_q, rd_pend1_d;
  logic          win_s;

  rr_pick u_rr_pick (
    .req0_i (r0_req),
    .req1_i (r1_req),
    .ptr_i  (rr_ptr_q),
    .win_o  (win_s)
  );

  // State, pointer, burst counter and read-pending registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      rr_ptr_q   <= REQ0;
      beat_cnt_q <= '0;
      rd_pend0_q <= 1'b0;
      rd_pend1_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      beat_cnt_q <= beat_cnt_d;
      rd_pend0_q <= rd_pend0_d;
      rd_pend1_q <= rd_pend1_d;
    end
  end

  // Next-state, grant and memory command mux.
  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    beat_cnt_d = beat_cnt_q;
    rd_pend0_d = 1'b0;
    rd_pend1_d = 1'b0;
    r0_gnt     = 1'b0;
    r1_gnt     = 1'b0;
    mem_wr     = 1'b0;
    mem_addr   = '0;
    mem_din    = '0;
    case (state_q)
      IDLE: begin
        beat_cnt_d = '0;
        if (r0_req || r1_req) begin
          state_d = (win_s == REQ1) ? OWN1 : OWN0;
        end else begin
          state_d = IDLE;
        end
      end
      OWN0: begin
        r0_gnt     = r0_req;
        mem_addr   = r0_addr;
        mem_din    = r0_wdata;
        mem_wr     = r0_req & r0_we;
        rd_pend0_d = r0_req & ~r0_we;
        if (!r0_req) begin
          state_d    = IDLE;
          rr_ptr_d   = REQ1;
          beat_cnt_d = '0;
        end else if (beat_cnt_q == LAST_BEAT) begin
          // Burst exhausted: hand over without a bubble if r1 is waiting.
          beat_cnt_d = '0;
          if (r1_req) begin
            state_d  = OWN1;
            rr_ptr_d = REQ0;
          end else begin
            state_d  = OWN0;
          end
        end else begin
          beat_cnt_d = beat_cnt_q + CW'(1);
        end
      end
      OWN1: begin
        r1_gnt     = r1_req;
        mem_addr   = r1_addr;
        mem_din    = r1_wdata;
        mem_wr     = r1_req & r1_we;
        rd_pend1_d = r1_req & ~r1_we;
        if (!r1_req) begin
          state_d    = IDLE;
          rr_ptr_d   = REQ0;
          beat_cnt_d = '0;
        end else if (beat_cnt_q == LAST_BEAT) begin
          beat_cnt_d = '0;
          if (r0_req) begin
            state_d  = OWN0;
            rr_ptr_d = REQ1;
          end else begin
            state_d  = OWN1;
          end
        end else begin
          beat_cnt_d = beat_cnt_q + CW'(1);
        end
      end
      default: begin
        state_d    = IDLE;
        beat_cnt_d = '0;
      end
    endcase
  end

  assign r0_rvalid = rd_pend0_q;
  assign r1_rvalid = rd_pend1_q;
  assign rdata     = mem_dout;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomised and directed bench for mem_port_arbiter with a behavioural memory,
// a transaction-level arbiter model and a read-return scoreboard.
module tb_mem_port_arbiter;
  localparam int DATA  = 18;
  localparam int ADDR  = 14;
  localparam int BURST = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            r0_req = 1'b0, r0_we = 1'b0, r1_req = 1'b0, r1_we = 1'b0;
  logic [ADDR-1:0] r0_addr = '0, r1_addr = '0;
  logic [DATA-1:0] r0_wdata = '0, r1_wdata = '0;
  logic            r0_gnt, r1_gnt, r0_rvalid, r1_rvalid, mem_wr;
  logic [DATA-1:0] rdata, mem_din, mem_dout;
  logic [ADDR-1:0] mem_addr;

  always #5 clk = ~clk;

  mem_port_arbiter #(.DATA(DATA), .ADDR(ADDR), .BURST(BURST)) dut (
    .clk(clk), .rst(rst),
    .r0_req(r0_req), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
    .r0_gnt(r0_gnt), .r0_rvalid(r0_rvalid),
    .r1_req(r1_req), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
    .r1_gnt(r1_gnt), .r1_rvalid(r1_rvalid),
    .rdata(rdata), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_din(mem_din),
    .mem_dout(mem_dout)
  );

  function automatic logic [DATA-1:0] init_pat(input int a);
    if (a >= 16 && a <= 19) return DATA'(32'hA1 + a - 16);
    else return DATA'(a * 37 + 5);
  endfunction

  // Synchronous memory port with registered, write-first read data.
  logic [DATA-1:0] mem   [1 << ADDR];
  bit              mem_v [1 << ADDR];
  always @(posedge clk) begin
    if (mem_wr) begin
      mem[mem_addr]   <= mem_din;
      mem_v[mem_addr] <= 1'b1;
      mem_dout        <= mem_din;
    end else begin
      mem_dout <= mem_v[mem_addr] ? mem[mem_addr] : init_pat(int'(mem_addr));
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0, n_err = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  typedef struct { int due; logic [DATA-1:0] d; } exp_t;
  exp_t q0e[$], q1e[$];
  logic [DATA-1:0] ref_mem [int];
  int m_own = -1, m_pref = 0, m_beats = 0;
  logic g0_last, g1_last;
  int wr_seen, rv0_seen, rv1_seen;

  function automatic logic [DATA-1:0] ref_rd(input logic [ADDR-1:0] a);
    if (ref_mem.exists(int'(a))) return ref_mem[int'(a)];
    else return init_pat(int'(a));
  endfunction

  // Ownership model: who holds the port, who is preferred next, beats used.
  task automatic model_next(input logic q0, input logic q1);
    int n;
    logic mine, oth;
    if (m_own < 0) begin
      if (q0 && q1) m_own = m_pref;
      else if (q0) m_own = 0;
      else if (q1) m_own = 1;
      m_beats = 0;
    end else begin
      n    = m_own;
      mine = (n == 0) ? q0 : q1;
      oth  = (n == 0) ? q1 : q0;
      if (!mine) begin
        m_own = -1; m_pref = 1 - n; m_beats = 0;
      end else begin
        m_beats++;
        if (m_beats == BURST) begin
          m_beats = 0;
          if (oth) begin m_own = 1 - n; m_pref = n; end
        end
      end
    end
  endtask

  task automatic step(input logic q0, input logic w0, input logic [ADDR-1:0] a0,
                      input logic [DATA-1:0] d0, input logic q1, input logic w1,
                      input logic [ADDR-1:0] a1, input logic [DATA-1:0] d1);
    logic eg0, eg1, ewr;
    logic [ADDR-1:0] ea;
    logic [DATA-1:0] ed;
    @(negedge clk);
    r0_req = q0; r0_we = w0; r0_addr = a0; r0_wdata = d0;
    r1_req = q1; r1_we = w1; r1_addr = a1; r1_wdata = d1;
    #1;
    eg0 = 1'b0; eg1 = 1'b0; ewr = 1'b0; ea = '0; ed = '0;
    if (m_own == 0) begin eg0 = q0; ea = a0; ed = d0; ewr = q0 & w0; end
    else if (m_own == 1) begin eg1 = q1; ea = a1; ed = d1; ewr = q1 & w1; end
    chk("r0_gnt", 32'(r0_gnt), 32'(eg0));
    chk("r1_gnt", 32'(r1_gnt), 32'(eg1));
    chk("mem_wr", 32'(mem_wr), 32'(ewr));
    chk("mem_addr", 32'(mem_addr), 32'(ea));
    chk("mem_din", 32'(mem_din), 32'(ed));
    g0_last = r0_gnt; g1_last = r1_gnt;
    wr_seen += int'(mem_wr); rv0_seen += int'(r0_rvalid); rv1_seen += int'(r1_rvalid);
    if (eg0) begin
      if (w0) ref_mem[int'(a0)] = d0;
      else q0e.push_back('{cyc + 1, ref_rd(a0)});
    end
    if (eg1) begin
      if (w1) ref_mem[int'(a1)] = d1;
      else q1e.push_back('{cyc + 1, ref_rd(a1)});
    end
    model_next(q0, q1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
  endtask

  // Asserts reset mid-cycle with the current requests still applied.
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_r0_gnt", 32'(r0_gnt), 32'd0);
    chk("rst_r1_gnt", 32'(r1_gnt), 32'd0);
    chk("rst_r0_rvalid", 32'(r0_rvalid), 32'd0);
    chk("rst_r1_rvalid", 32'(r1_rvalid), 32'd0);
    chk("rst_mem_wr", 32'(mem_wr), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_mem_din", 32'(mem_din), 32'd0);
    r0_req = 1'b0; r1_req = 1'b0; r0_we = 1'b0; r1_we = 1'b0;
    m_own = -1; m_pref = 0; m_beats = 0;
    q0e.delete(); q1e.delete();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic mon_one(input int n, input logic rv);
    exp_t e;
    bit have;
    have = 1'b0;
    if (n == 0 && q0e.size() > 0) begin e = q0e[0]; have = 1'b1; end
    if (n == 1 && q1e.size() > 0) begin e = q1e[0]; have = 1'b1; end
    if (rv === 1'b1) begin
      if (!have) begin
        n_vec++; n_err++;
        $display("FAIL spurious_rvalid r%0d: got rvalid=1, expected 0 (cycle %0d)", n, cyc);
      end else begin
        if (n == 0) void'(q0e.pop_front()); else void'(q1e.pop_front());
        chk(n == 0 ? "r0_rdata" : "r1_rdata", 32'(rdata), 32'(e.d));
        chk(n == 0 ? "r0_rd_latency" : "r1_rd_latency", 32'(cyc), 32'(e.due));
      end
    end else if (have && e.due <= cyc) begin
      n_vec++; n_err++;
      $display("FAIL missing_rvalid r%0d: got rvalid=%b, expected 1 (cycle %0d)", n, rv, cyc);
      if (n == 0) void'(q0e.pop_front()); else void'(q1e.pop_front());
    end
  endtask

  // Read-return monitor, independent of stimulus.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      mon_one(0, r0_rvalid);
      mon_one(1, r1_rvalid);
    end
  end

  initial begin
    int n, first1, back0;
    logic [ADDR-1:0] ra;
    logic s0, s1;
    do_reset();

    // Single reader, back-to-back reads of the preloaded words.
    ra = 14'h0010; n = 0;
    while (ra != 14'h0014 && n < 10) begin
      step(1'b1, 1'b0, ra, '0, 1'b0, 1'b0, '0, '0);
      n++;
      if (g0_last) ra = ra + 14'd1;
    end
    chk("reader_cycles", 32'(n), 32'd5);
    rv0_seen = 0;
    idle(3);
    chk("reader_rvalid_tail", 32'(rv0_seen), 32'd1);

    // Write by r1, then read back by r0.
    wr_seen = 0; rv0_seen = 0; rv1_seen = 0; n = 0;
    do begin
      step(1'b0, 1'b0, '0, '0, 1'b1, 1'b1, 14'h3FFF, 18'h3FFFF); n++;
    end while (!g1_last && n < 6);
    n = 0;
    do begin
      step(1'b1, 1'b0, 14'h3FFF, '0, 1'b0, 1'b0, '0, '0); n++;
    end while (!g0_last && n < 6);
    chk("wb_read_wait", 32'(n), 32'd3);
    idle(2);
    chk("wb_wr_pulses", 32'(wr_seen), 32'd1);
    chk("wb_r1_rvalid", 32'(rv1_seen), 32'd0);
    chk("wb_r0_rvalid", 32'(rv0_seen), 32'd1);

    // Contention from reset: r0 first, then alternate every BURST beats.
    do_reset();
    first1 = -1; back0 = -1;
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 1'b0, 14'($urandom_range(0, 31)), '0, 1'b1, 1'b0, 14'($urandom_range(0, 31)), '0);
      if (g1_last && first1 < 0) first1 = i;
      if (g0_last && first1 >= 0 && back0 < 0) back0 = i;
    end
    chk("contend_first_r1", 32'(first1), 32'd5);
    chk("contend_back_r0", 32'(back0), 32'd9);
    idle(3);

    // Simultaneous arrival after r0 was last owner: r1 wins.
    do_reset();
    step(1'b1, 1'b0, 14'h0001, '0, 1'b0, 1'b0, '0, '0);
    step(1'b1, 1'b0, 14'h0001, '0, 1'b0, 1'b0, '0, '0);
    idle(1);
    step(1'b1, 1'b0, 14'h0002, '0, 1'b1, 1'b0, 14'h0003, '0);
    step(1'b1, 1'b0, 14'h0002, '0, 1'b1, 1'b0, 14'h0003, '0);
    chk("simul_r1_wins", 32'(g1_last), 32'd1);
    chk("simul_r0_waits", 32'(g0_last), 32'd0);
    idle(3);

    // Reset in the middle of an r0 burst, then r1 alone.
    step(1'b1, 1'b0, 14'h0010, '0, 1'b0, 1'b0, '0, '0);
    step(1'b1, 1'b0, 14'h0011, '0, 1'b0, 1'b0, '0, '0);
    step(1'b1, 1'b0, 14'h0012, '0, 1'b0, 1'b0, '0, '0);
    do_reset();
    step(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 14'h0013, '0);
    chk("post_rst_bubble", 32'(g1_last), 32'd0);
    step(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 14'h0013, '0);
    chk("post_rst_r1_gnt", 32'(g1_last), 32'd1);
    idle(3);

    // Random traffic with sticky requests.
    s0 = 1'b0; s1 = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      s0 = s0 ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 2) == 0);
      s1 = s1 ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 2) == 0);
      step(s0, ($urandom_range(0, 2) == 0),
           ($urandom_range(0, 9) == 0) ? 14'h3FFF : 14'($urandom_range(0, 15)),
           DATA'($urandom),
           s1, ($urandom_range(0, 2) == 0),
           ($urandom_range(0, 9) == 0) ? 14'h3FFF : 14'($urandom_range(0, 15)),
           DATA'($urandom));
    end
    idle(4);
    chk("queue_drain", 32'(q0e.size() + q1e.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
